// File: rtl/mips_trace_buffer_if.sv
// Capture-side and readout-side signals of the MIPS output trace buffer.
// master is the buffer itself; slave is the producer/consumer driving it.
interface mips_trace_buffer_if #(
   parameter int unsigned DATA_W = 9,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned TS_W   = 16
);
   logic                     en;
   logic [DATA_W-1:0]        din;
   logic                     rd_valid;
   logic                     rd_ready;
   logic [DATA_W-1:0]        rd_data;
   logic [TS_W-1:0]          rd_ts;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     clr_ovf;

   modport master (
      input  en, din, rd_ready, clr_ovf,
      output rd_valid, rd_data, rd_ts, count, overflow
   );

   modport slave (
      output en, din, rd_ready, clr_ovf,
      input  rd_valid, rd_data, rd_ts, count, overflow
   );
endinterface

// File: rtl/mips_trace_buffer.sv
// Records the core output bus into a first-word-fall-through FIFO, each entry tagged
// with a cycle timestamp; optional change-only capture and sticky overflow flag.
module mips_trace_buffer #(
   parameter int unsigned DATA_W      = 9,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned TS_W        = 16,
   parameter bit          MODE_CHANGE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   mips_trace_buffer_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [TS_W-1:0]   mem_ts   [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic              primed_q, primed_d;
   logic [DATA_W-1:0] last_q, last_d;
   logic              ovf_q, ovf_d;

   logic capture, full, push, pop, drop;

   always_comb begin
      capture  = bus.en && (!MODE_CHANGE || !primed_q || (bus.din != last_q));
      full     = (count_q == CW'(DEPTH));
      pop      = (count_q != '0) && bus.rd_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      push     = capture && (!full || pop);
      drop     = capture && full && !pop;

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      ts_d     = bus.en ? ts_q + TS_W'(1) : ts_q;
      primed_d = bus.en;
      last_d   = bus.en ? bus.din : last_q;

      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ts_q     <= '0;
         primed_q <= 1'b0;
         last_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ts_q     <= ts_d;
         primed_q <= primed_d;
         last_q   <= last_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is never cleared; only the write is suppressed while in reset.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem_data[wr_ptr_q] <= bus.din;
         mem_ts[wr_ptr_q]   <= ts_q;
      end
   end

   assign bus.rd_valid = (count_q != '0);
   assign bus.rd_data  = mem_data[rd_ptr_q];
   assign bus.rd_ts    = mem_ts[rd_ptr_q];
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;
endmodule
